// File: rtl/ct_idu_ereg_pkg.sv
// Shared definitions for the ereg fflags accumulate path: flag width,
// flag bit positions, accumulator FSM encoding and the flag merge helper.
package ct_idu_ereg_pkg;

    localparam int FLAG_W    = 6;

    // Bit positions inside a FLAG_W-wide flag vector
    localparam int FLG_NX    = 0;
    localparam int FLG_UF    = 1;
    localparam int FLG_OF    = 2;
    localparam int FLG_DZ    = 3;
    localparam int FLG_NV    = 4;
    localparam int FLG_VXSAT = 5;

    localparam logic [FLAG_W-1:0] FLAGS_ZERO = {FLAG_W{1'b0}};

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } fflags_state_e;

    // Flags only ever accumulate: merging is a plain bitwise OR
    function automatic logic [FLAG_W-1:0] flag_merge(
        input logic [FLAG_W-1:0] a,
        input logic [FLAG_W-1:0] b
    );
        flag_merge = a | b;
    endfunction

endpackage

// File: rtl/ct_idu_ereg_or_tree.sv
// NUM_EREG-way, FLAG_W-bit OR reduction of the per-entry accumulate outputs.
// Purely combinational; the caller registers the result.
module ct_idu_ereg_or_tree #(
    parameter int NUM_EREG = 32,
    parameter int FLAG_W   = 6
) (
    input  logic [NUM_EREG*FLAG_W-1:0] acc_dout,
    output logic [FLAG_W-1:0]          flags_or
);

    // Fold every entry's flag slice into one vector
    always_comb begin
        flags_or = {FLAG_W{1'b0}};
        for (int i = 0; i < NUM_EREG; i++) begin
            flags_or = flags_or | acc_dout[i*FLAG_W +: FLAG_W];
        end
    end

endmodule

// File: rtl/ct_idu_rf_ereg_fflags_acc.sv
// Collects exception flags of retired ereg entries and hands them to CP0.
//   ereg_acc_dout -> OR tree -> S1 register -> (optional filter) -> FSM/out register
// Flags that arrive while CP0 is back-pressuring are merged into a pending
// accumulator and sent as the next transfer, so no bit is dropped.
// Optional feature: define CT_IDU_EREG_FFLAGS_FILTER_EN to suppress S1 bits that
// are already set architecturally (cp0_idu_fflags_cur) or already queued.
module ct_idu_rf_ereg_fflags_acc
    import ct_idu_ereg_pkg::*;
#(
    parameter int NUM_EREG = 32
) (
    input  logic                       forever_cpuclk,
    input  logic                       cpurst,
    input  logic [NUM_EREG*FLAG_W-1:0] ereg_acc_dout,
    input  logic                       cp0_idu_fflags_ack,
    input  logic [FLAG_W-1:0]          cp0_idu_fflags_cur,
    output logic                       idu_cp0_fflags_vld,
    output logic [FLAG_W-1:0]          idu_cp0_fflags,
    output logic                       idu_rtu_fflags_empty
);

    logic [FLAG_W-1:0] acc_or_s;
    logic [FLAG_W-1:0] s1_flags_r;
    logic [FLAG_W-1:0] s1_eff_s;
    logic              s1_evt_s;
    logic [FLAG_W-1:0] merge_s;
    logic [FLAG_W-1:0] pend_r;
    logic [FLAG_W-1:0] pend_nxt_s;
    logic [FLAG_W-1:0] out_flags_r;
    logic [FLAG_W-1:0] out_nxt_s;
    fflags_state_e     state_r;
    fflags_state_e     state_nxt_s;

    ct_idu_ereg_or_tree #(
        .NUM_EREG (NUM_EREG),
        .FLAG_W   (FLAG_W)
    ) u_or_tree (
        .acc_dout (ereg_acc_dout),
        .flags_or (acc_or_s)
    );

`ifdef CT_IDU_EREG_FFLAGS_FILTER_EN
    logic [FLAG_W-1:0] queued_s;

    // Drop S1 bits already in fcsr or already waiting to go to CP0
    always_comb begin
        queued_s = FLAGS_ZERO;
        if (state_r == SEND) begin
            queued_s = flag_merge(out_flags_r, pend_r);
        end else begin
            queued_s = FLAGS_ZERO;
        end
        s1_eff_s = s1_flags_r & ~cp0_idu_fflags_cur & ~queued_s;
    end
`else
    // The architectural flags are only needed by the filter
    logic [FLAG_W-1:0] unused_fflags_cur_s;
    assign unused_fflags_cur_s = cp0_idu_fflags_cur;
    assign s1_eff_s            = s1_flags_r;
`endif

    assign s1_evt_s = |s1_eff_s;
    assign merge_s  = flag_merge(pend_r, s1_eff_s);

    // Next-state and next-data for the transfer FSM; an ack is only
    // meaningful while a transfer is being presented
    always_comb begin
        state_nxt_s = state_r;
        out_nxt_s   = out_flags_r;
        pend_nxt_s  = pend_r;
        case (state_r)
            IDLE: begin
                if (s1_evt_s) begin
                    state_nxt_s = SEND;
                    out_nxt_s   = s1_eff_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (!cp0_idu_fflags_ack) begin
                    // Output held stable; new flags wait in pend
                    pend_nxt_s = merge_s;
                end else if (|merge_s) begin
                    // Back-to-back transfer of everything gathered so far
                    state_nxt_s = SEND;
                    out_nxt_s   = merge_s;
                    pend_nxt_s  = FLAGS_ZERO;
                end else begin
                    state_nxt_s = IDLE;
                    out_nxt_s   = FLAGS_ZERO;
                    pend_nxt_s  = FLAGS_ZERO;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                out_nxt_s   = FLAGS_ZERO;
                pend_nxt_s  = FLAGS_ZERO;
            end
        endcase
    end

    // State registers: S1 captures the OR tree every cycle; reset discards
    // in-flight flags since fcsr is reset at the same time
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            s1_flags_r  <= FLAGS_ZERO;
            pend_r      <= FLAGS_ZERO;
            out_flags_r <= FLAGS_ZERO;
            state_r     <= IDLE;
        end else begin
            s1_flags_r  <= acc_or_s;
            pend_r      <= pend_nxt_s;
            out_flags_r <= out_nxt_s;
            state_r     <= state_nxt_s;
        end
    end

    assign idu_cp0_fflags_vld   = (state_r == SEND);
    assign idu_cp0_fflags       = out_flags_r;
    assign idu_rtu_fflags_empty = (state_r == IDLE) & ~s1_evt_s & ~(|pend_r);

endmodule

// File: tb/tb_ct_idu_rf_ereg_fflags_acc.sv
// Scenario bench for ct_idu_rf_ereg_fflags_acc. Expected CP0 transfers are
// queued when stimulus is driven and popped when a transfer is observed.
module tb_ct_idu_rf_ereg_fflags_acc;

    localparam int NUM = 32;
    localparam int FW  = 6;

    logic              clk;
    logic              cpurst;
    logic [NUM*FW-1:0] acc_dout;
    logic              ack;
    logic [FW-1:0]     cur;
    logic              vld;
    logic [FW-1:0]     fflags;
    logic              empty;

    int                checks;
    int                errors;
    int                xfers;
    logic [FW-1:0]     exp_v;
    logic [FW-1:0]     exp_q[$];

    ct_idu_rf_ereg_fflags_acc #(.NUM_EREG(NUM)) dut (
        .forever_cpuclk       (clk),
        .cpurst               (cpurst),
        .ereg_acc_dout        (acc_dout),
        .cp0_idu_fflags_ack   (ack),
        .cp0_idu_fflags_cur   (cur),
        .idu_cp0_fflags_vld   (vld),
        .idu_cp0_fflags       (fflags),
        .idu_rtu_fflags_empty (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        cpurst = 1'b1; ack = 1'b0; acc_dout = '0; cur = 6'h00;
        step; step;
        checks++; if (vld !== 1'b0)    begin errors++; $display("FAIL reset_vld: got %b expected 0", vld); end
        checks++; if (fflags !== 6'h00) begin errors++; $display("FAIL reset_fflags: got %h expected 00", fflags); end
        checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        cpurst = 1'b0;
        step;
    endtask

    task automatic test_single;
        ack = 1'b1;
        acc_dout[3*FW +: FW] = 6'h01;
        exp_q.push_back(6'h01);
        step;
        acc_dout = '0;
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_s1: got %b expected 0", empty); end
        checks++; if (vld !== 1'b0)   begin errors++; $display("FAIL single_vld_early: got %b expected 0", vld); end
        step;
        checks++; if (vld !== 1'b1)   begin errors++; $display("FAIL single_vld: got %b expected 1", vld); end
        exp_v = exp_q.pop_front();
        checks++; if (fflags !== exp_v) begin errors++; $display("FAIL single_data: got %h expected %h", fflags, exp_v); end
        step;
        checks++; if (vld !== 1'b0)   begin errors++; $display("FAIL single_vld_drop: got %b expected 0", vld); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_end: got %b expected 1", empty); end
    endtask

    task automatic test_multi_or;
        ack = 1'b1;
        acc_dout[0*FW +: FW]  = 6'h04;
        acc_dout[31*FW +: FW] = 6'h20;
        exp_q.push_back(6'h24);
        step;
        acc_dout = '0;
        xfers = 0;
        for (int c = 0; c < 6; c++) begin
            step;
            if (vld === 1'b1 && ack === 1'b1) begin
                xfers++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL multi_extra: got transfer %h expected none", fflags);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (fflags !== exp_v) begin errors++; $display("FAIL multi_data: got %h expected %h", fflags, exp_v); end
                end
            end
        end
        checks++; if (xfers !== 1) begin errors++; $display("FAIL multi_count: got %0d expected 1", xfers); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL multi_missing: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_backpressure;
        ack = 1'b0;
        acc_dout[5*FW +: FW] = 6'h01;
        exp_q.push_back(6'h01);
        exp_q.push_back(6'h0A);
        step;
        acc_dout = '0;
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL bp_empty_s1: got %b expected 0", empty); end
        step;
        for (int c = 0; c < 5; c++) begin
            checks++; if (vld !== 1'b1)    begin errors++; $display("FAIL bp_hold_vld[%0d]: got %b expected 1", c, vld); end
            checks++; if (fflags !== 6'h01) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h expected 01", c, fflags); end
            checks++; if (empty !== 1'b0)  begin errors++; $display("FAIL bp_hold_empty[%0d]: got %b expected 0", c, empty); end
            acc_dout = '0;
            if (c == 0) acc_dout[7*FW +: FW] = 6'h02;
            if (c == 2) acc_dout[9*FW +: FW] = 6'h08;
            if (c < 4) step;
        end
        ack = 1'b1;
        exp_v = exp_q.pop_front();
        checks++; if (fflags !== exp_v) begin errors++; $display("FAIL bp_first: got %h expected %h", fflags, exp_v); end
        step;
        checks++; if (vld !== 1'b1) begin errors++; $display("FAIL bp_second_vld: got %b expected 1", vld); end
        exp_v = exp_q.pop_front();
        checks++; if (fflags !== exp_v) begin errors++; $display("FAIL bp_second_data: got %h expected %h", fflags, exp_v); end
        step;
        checks++; if (vld !== 1'b0)   begin errors++; $display("FAIL bp_end_vld: got %b expected 0", vld); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bp_end_empty: got %b expected 1", empty); end
    endtask

    task automatic test_ack_with_event;
        ack = 1'b0;
        acc_dout[2*FW +: FW] = 6'h01;
        exp_q.push_back(6'h01);
        exp_q.push_back(6'h10);
        step;
        acc_dout = '0;
        step;
        checks++; if (vld !== 1'b1)    begin errors++; $display("FAIL ae_vld: got %b expected 1", vld); end
        acc_dout[4*FW +: FW] = 6'h10;
        step;
        acc_dout = '0;
        ack = 1'b1;
        exp_v = exp_q.pop_front();
        checks++; if (fflags !== exp_v) begin errors++; $display("FAIL ae_first: got %h expected %h", fflags, exp_v); end
        step;
        checks++; if (vld !== 1'b1)    begin errors++; $display("FAIL ae_no_bubble: got %b expected 1", vld); end
        exp_v = exp_q.pop_front();
        checks++; if (fflags !== exp_v) begin errors++; $display("FAIL ae_second: got %h expected %h", fflags, exp_v); end
        step;
        checks++; if (vld !== 1'b0)    begin errors++; $display("FAIL ae_end_vld: got %b expected 0", vld); end
    endtask

    task automatic test_reset_mid_send;
        ack = 1'b0;
        acc_dout[6*FW +: FW] = 6'h01;
        step;
        acc_dout = '0;
        step;
        acc_dout[8*FW +: FW] = 6'h3F;
        step;
        acc_dout = '0;
        step;
        checks++; if (vld !== 1'b1)   begin errors++; $display("FAIL rm_pre_vld: got %b expected 1", vld); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL rm_pre_empty: got %b expected 0", empty); end
        cpurst = 1'b1;
        step;
        cpurst = 1'b0;
        checks++; if (vld !== 1'b0)     begin errors++; $display("FAIL rm_vld: got %b expected 0", vld); end
        checks++; if (fflags !== 6'h00) begin errors++; $display("FAIL rm_fflags: got %h expected 00", fflags); end
        checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL rm_empty: got %b expected 1", empty); end
        ack = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step;
            checks++; if (vld !== 1'b0) begin errors++; $display("FAIL rm_stale[%0d]: got vld %b expected 0", c, vld); end
        end
    endtask

    task automatic test_filter;
        logic [FW-1:0] stim[2];
        int            want;
        stim[0] = 6'h01;
        stim[1] = 6'h03;
        ack = 1'b1;
        cur = 6'h01;
`ifdef CT_IDU_EREG_FFLAGS_FILTER_EN
        exp_q.push_back(6'h02);
        want = 1;
`else
        exp_q.push_back(6'h01);
        exp_q.push_back(6'h03);
        want = 2;
`endif
        xfers = 0;
        for (int s = 0; s < 2; s++) begin
            acc_dout[(10+s)*FW +: FW] = stim[s];
            step;
            acc_dout = '0;
            for (int c = 0; c < 5; c++) begin
                step;
                if (vld === 1'b1 && ack === 1'b1) begin
                    xfers++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL filt_extra: got transfer %h expected none", fflags);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (fflags !== exp_v) begin errors++; $display("FAIL filt_data: got %h expected %h", fflags, exp_v); end
                    end
                end
            end
        end
        checks++; if (xfers !== want) begin errors++; $display("FAIL filt_count: got %0d expected %0d", xfers, want); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL filt_missing: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
        cur = 6'h00;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cpurst   = 1'b1;
        acc_dout = '0;
        ack      = 1'b0;
        cur      = 6'h00;
        test_reset;
        test_single;
        test_multi_or;
        test_backpressure;
        test_ack_with_event;
        test_reset_mid_send;
        test_filter;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
